issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued decoded instructions (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  discard all queued entries and any pending branch wait.
REQ-005 SHALL have port decoded_instr_i  input  scoreboard_entry_t  decoded instruction from the ID stage.
REQ-006 SHALL have port decoded_instr_valid_i  input  1  decoded_instr_i valid.
REQ-007 SHALL have port is_ctrl_flow_i  input  1  decoded instruction is a branch/jump.
REQ-008 SHALL have port decoded_instr_ack_o  output  1  entry accepted this cycle.
REQ-009 SHALL have port issue_instr_o  output  scoreboard_entry_t  head entry toward the issue stage.
REQ-010 SHALL have port issue_instr_valid_o  output  1  issue_instr_o valid.
REQ-011 SHALL have port is_ctrl_flow_o  output  1  head entry is control flow.
REQ-012 SHALL have port issue_ack_i  input  1  issue stage consumed head entry.
REQ-013 SHALL have port resolve_branch_i  input  1  EX resolved the outstanding control-flow instruction.
REQ-014 SHALL have port count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL store entries in FIFO order: write pointer, read pointer, both $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-016 SHALL assert decoded_instr_ack_o = decoded_instr_valid_i & ~full & ~flush_i; push occurs exactly when ack is high.
REQ-017 SHALL define full as count_o == DEPTH and empty as count_o == 0; a pop in the same cycle SHALL NOT free space for a push (no pass-through when full).
REQ-018 SHALL store is_ctrl_flow_i alongside each entry and present it on is_ctrl_flow_o with the head.
REQ-019 SHALL drive issue_instr_valid_o = ~empty & (state == IDLE) & ~flush_i; issue_instr_o/is_ctrl_flow_o SHALL always show the head slot.
REQ-020 SHALL pop when issue_instr_valid_o & issue_ack_i; issue_ack_i without valid SHALL be ignored.
REQ-021 SHALL have latency 1: an entry pushed in cycle N is first visible on issue_instr_o in cycle N+1 (no combinational bypass).
REQ-022 SHALL update count_o by +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
REQ-023 SHALL implement FSM states IDLE and WAIT_RESOLVE.
REQ-024 SHALL transition IDLE -> WAIT_RESOLVE when the popped entry has is_ctrl_flow set.
REQ-025 SHALL transition WAIT_RESOLVE -> IDLE on resolve_branch_i; first further pop possible the following cycle.
REQ-026 SHALL ignore resolve_branch_i in IDLE.
REQ-027 SHALL continue accepting pushes in WAIT_RESOLVE while not full.
REQ-028 SHALL on flush_i: next cycle count_o=0, pointers=0, state=IDLE; no push or pop takes effect in the flush cycle; flush has priority over resolve, push and pop.

Reset
REQ-029 SHALL on rst_i (synchronous, high) set pointers=0, count_o=0, state=IDLE, therefore issue_instr_valid_o=0, decoded_instr_ack_o follows REQ-016 with full=0 from next cycle.
REQ-030 SHALL, when reset asserts mid-operation, discard all entries and any branch wait; storage contents need not be cleared.
REQ-031 SHALL give reset priority over flush_i and all handshakes.

Structure
REQ-032 SHALL take scoreboard_entry_t from ariane_pkg; a constant ISSUE_QUEUE_DEPTH (default 4) SHALL be added to ariane_pkg and used at instantiation.
REQ-033 SHALL contain one sub-module, issue_queue_fifo (storage, pointers, count); the FSM and handshake gating live in issue_queue.

Verification
REQ-034 SHALL cover: push 4 non-ctrl entries A..D with issue_ack_i=0 -> count_o=4, ack low on 5th push, head A; then ack each cycle -> A,B,C,D in order, count 0.
REQ-035 SHALL cover: push branch X then Y, issue_ack_i=1 -> X popped, valid low while waiting; resolve_branch_i pulse at cycle 5 -> Y valid in cycle 6.
REQ-036 SHALL cover: count_o=2 with simultaneous push and pop -> count_o stays 2, FIFO order preserved across pointer wrap after 10 operations.
REQ-037 SHALL cover: count_o=3 in WAIT_RESOLVE, flush_i with valid_i and resolve high -> next cycle count_o=0, state IDLE, pushed entry not stored.
REQ-038 SHALL cover: rst_i asserted with queue full -> next cycle count_o=0, issue_instr_valid_o=0, decoded_instr_ack_o=1 for a valid input.
REQ-039 SHALL cover: resolve_branch_i in IDLE with 1 entry -> entry issues normally, state stays IDLE.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core types: the decoded-instruction record carried from ID to issue,
// and the issue queue depth used wherever the queue is instantiated.
package ariane_pkg;

  localparam int ISSUE_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_queue_fifo.sv
// Circular storage for decoded instructions plus their control-flow flag,
// with read/write pointers and an occupancy count. Callers gate push/pop.
module issue_queue_fifo
  import ariane_pkg::*;
#(
  parameter int DEPTH = ISSUE_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  scoreboard_entry_t        wdata,
  input  logic                     wctrl,
  output scoreboard_entry_t        rdata,
  output logic                     rctrl,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  scoreboard_entry_t   mem_r [DEPTH];
  logic [DEPTH-1:0]    ctrl_mem_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;

  // Entry storage; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r]      <= wdata;
      ctrl_mem_r[wr_ptr_r] <= wctrl;
    end
  end

  // Pointers and occupancy; reset and clear both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign rctrl = ctrl_mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == DEPTH_CNT);
  assign empty = (count_r == {(PTR_W + 1){1'b0}});

endmodule

// File: rtl/issue_queue.sv
// Decoded-instruction issue queue: FIFO between ID and issue that stalls
// after issuing a branch/jump until EX reports it resolved.
module issue_queue
  import ariane_pkg::*;
#(
  parameter int DEPTH = ISSUE_QUEUE_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  scoreboard_entry_t      decoded_instr_i,
  input  logic                   decoded_instr_valid_i,
  input  logic                   is_ctrl_flow_i,
  output logic                   decoded_instr_ack_o,
  output scoreboard_entry_t      issue_instr_o,
  output logic                   issue_instr_valid_o,
  output logic                   is_ctrl_flow_o,
  input  logic                   issue_ack_i,
  input  logic                   resolve_branch_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam logic [0:0] IDLE         = 1'b0;
  localparam logic [0:0] WAIT_RESOLVE = 1'b1;

  logic [0:0] state_r;
  logic [0:0] state_next_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       head_ctrl_s;

  issue_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (flush_i),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (decoded_instr_i),
    .wctrl (is_ctrl_flow_i),
    .rdata (issue_instr_o),
    .rctrl (head_ctrl_s),
    .count (count_o),
    .full  (full_s),
    .empty (empty_s)
  );

  // Handshake gating: space freed by a same-cycle pop is not reused.
  always_comb begin
    push_s              = decoded_instr_valid_i & ~full_s & ~flush_i;
    issue_instr_valid_o = ~empty_s & (state_r == IDLE) & ~flush_i;
    pop_s               = issue_instr_valid_o & issue_ack_i;
  end

  assign decoded_instr_ack_o = push_s;
  assign is_ctrl_flow_o      = head_ctrl_s;

  // Branch-wait FSM next state; flush abandons any outstanding wait.
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s && head_ctrl_s) begin
            state_next_s = WAIT_RESOLVE;
          end else begin
            state_next_s = IDLE;
          end
        end
        WAIT_RESOLVE: begin
          if (resolve_branch_i) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = WAIT_RESOLVE;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model of the issue rules.
module tb_issue_queue;
  import ariane_pkg::*;

  localparam int DEPTH = ISSUE_QUEUE_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              decoded_instr_valid_i;
  logic              is_ctrl_flow_i;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic              issue_instr_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_ack_i;
  logic              resolve_branch_i;
  logic [CW-1:0]     count_o;

  issue_queue #(
    .DEPTH (ISSUE_QUEUE_DEPTH)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .is_ctrl_flow_o        (is_ctrl_flow_o),
    .issue_ack_i           (issue_ack_i),
    .resolve_branch_i      (resolve_branch_i),
    .count_o               (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain queues of stored entries plus a "waiting on branch" flag.
  scoreboard_entry_t m_data[$];
  bit                m_ctrl[$];
  bit                m_wait = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic scoreboard_entry_t mk(input int i);
    scoreboard_entry_t e;
    e.pc = 32'h0000_1000 + 32'(i * 4);
    e.op = 7'(i + 7'd3);
    e.rd = 5'(i);
    return e;
  endfunction

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic cycle(input logic r, input logic f, input logic v, input logic c,
                       input scoreboard_entry_t d, input logic ia, input logic rb);
    bit exp_ack;
    bit exp_valid;
    bit popped_ctrl;
    rst_i = r; flush_i = f; decoded_instr_valid_i = v; is_ctrl_flow_i = c;
    decoded_instr_i = d; issue_ack_i = ia; resolve_branch_i = rb;
    #1;
    exp_ack   = v && (m_data.size() != DEPTH) && !f;
    exp_valid = (m_data.size() != 0) && !m_wait && !f;
    check("ack", 64'(decoded_instr_ack_o), 64'(exp_ack));
    check("valid", 64'(issue_instr_valid_o), 64'(exp_valid));
    check("count", 64'(count_o), 64'(m_data.size()));
    if (m_data.size() != 0) begin
      check("head", 64'(issue_instr_o), 64'(m_data[0]));
      check("head_ctrl", 64'(is_ctrl_flow_o), 64'(m_ctrl[0]));
    end
    @(posedge clk_i);
    if (r || f) begin
      m_data.delete();
      m_ctrl.delete();
      m_wait = 1'b0;
    end else begin
      if (exp_valid && ia) begin
        popped_ctrl = m_ctrl.pop_front();
        void'(m_data.pop_front());
        m_wait = popped_ctrl;
      end else if (m_wait && rb) begin
        m_wait = 1'b0;
      end
      if (exp_ack) begin
        m_data.push_back(d);
        m_ctrl.push_back(c);
      end
    end
    #1;
  endtask

  initial begin
    scoreboard_entry_t z;
    z = '0;
    rst_i = 1'b1; flush_i = 1'b0; decoded_instr_valid_i = 1'b0; is_ctrl_flow_i = 1'b0;
    decoded_instr_i = z; issue_ack_i = 1'b0; resolve_branch_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check("reset_count", 64'(count_o), 64'd0);
    check("reset_valid", 64'(issue_instr_valid_o), 64'd0);

    // Fill with A..D, fifth push refused, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(i), 1'b0, 1'b0);
    check("full_count", 64'(count_o), 64'(DEPTH));
    check("full_head", 64'(issue_instr_o), 64'(mk(0)));
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(issue_instr_o), 64'(mk(i)));
      cycle(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 1'b0);
    end
    check("drained_count", 64'(count_o), 64'd0);

    // Branch X then Y: X issues, queue stalls until resolve, then Y issues.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(10), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(11), 1'b1, 1'b0);
    check("wait_valid_low", 64'(issue_instr_valid_o), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 1'b1);
    check("resolved_valid", 64'(issue_instr_valid_o), 64'd1);
    check("resolved_head", 64'(issue_instr_o), 64'(mk(11)));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 1'b0);

    // Steady state at two entries with simultaneous push/pop across pointer wrap.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(20), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(21), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(22 + i), 1'b1, 1'b0);
    check("steady_count", 64'(count_o), 64'd2);
    check("steady_head", 64'(issue_instr_o), 64'(mk(30)));

    // Flush with three entries while waiting on a branch, push and resolve high.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(40), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(41), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(42), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(43), 1'b0, 1'b0);
    check("pre_flush_count", 64'(count_o), 64'd3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, mk(44), 1'b0, 1'b1);
    check("flush_count", 64'(count_o), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(45), 1'b0, 1'b0);
    check("post_flush_idle", 64'(issue_instr_valid_o), 64'd1);
    check("post_flush_head", 64'(issue_instr_o), 64'(mk(45)));

    // Reset while full, with a valid input presented.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(50 + i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, mk(55), 1'b0, 1'b0);
    decoded_instr_valid_i = 1'b1; #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(issue_instr_valid_o), 64'd0);
    check("rst_ack", 64'(decoded_instr_ack_o), 64'd1);

    // Resolve in IDLE is ignored: single entry issues, queue stays live.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(60), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(61), 1'b1, 1'b1);
    check("idle_resolve_valid", 64'(issue_instr_valid_o), 64'd1);
    check("idle_resolve_head", 64'(issue_instr_o), 64'(mk(61)));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      scoreboard_entry_t rd;
      rd = scoreboard_entry_t'({$urandom, $urandom});
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rd,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
